// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the decode/execute boundary.
//               - ALU select codes.
//               - The ID/EX pipeline entry record.
//               - The skid-buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_XLEN = 32;
    localparam int c_REGW = 5;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_MUL  = 4'b0010;
    localparam logic [3:0] c_ALU_DIV  = 4'b0011;
    localparam logic [3:0] c_ALU_AND  = 4'b0100;
    localparam logic [3:0] c_ALU_OR   = 4'b0101;
    localparam logic [3:0] c_ALU_NOR  = 4'b0110;
    localparam logic [3:0] c_ALU_NOP  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1001;
    localparam logic [3:0] c_ALU_XOR  = 4'b1010;
    localparam logic [3:0] c_ALU_SLTI = 4'b1011;

    // Buffer occupancy: nothing, head only, head plus skid slot.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [c_XLEN-1:0] rs_val;
        logic [c_XLEN-1:0] rt_val;
        logic [c_XLEN-1:0] imm;
        logic [c_REGW-1:0] rs_idx;
        logic [c_REGW-1:0] rt_idx;
        logic [c_REGW-1:0] rd;
        logic [3:0]        sel;
        logic              use_imm;
        logic              reg_write;
    } id_ex_entry_t;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand forwarding select for one source register.
//               EX/MEM wins over MEM/WB; register 0 is never forwarded.
// Ports       : idx       - source register index
//               rf_val    - value currently held for that source
//               exmem_*   - EX/MEM result bus (wen, rd, res)
//               memwb_*   - MEM/WB result bus (wen, rd, res)
//               fwd_val   - resolved operand
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [W-1:0]  rf_val,
    input  logic          exmem_wen,
    input  logic [RW-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_res,
    input  logic          memwb_wen,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_res,
    output logic [W-1:0]  fwd_val
);

    logic w_nonzero;
    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_nonzero   = (idx != '0);
    assign w_exmem_hit = exmem_wen && (exmem_rd == idx) && w_nonzero;
    assign w_memwb_hit = memwb_wen && (memwb_rd == idx) && w_nonzero;

    always_comb begin
        fwd_val = rf_val;
        if (w_exmem_hit) begin
            fwd_val = exmem_res;
        end else if (w_memwb_hit) begin
            fwd_val = memwb_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode-to-execute stage with a 2-entry skid buffer and RAW
//               forwarding from EX/MEM and MEM/WB. ALU inputs are driven from
//               the head entry register. W and RW must match the package
//               entry widths (c_XLEN, c_REGW).
// Ports       : clk, rst_n (async, active-low), flush
//               in_*   - decode-side valid/ready and decoded fields
//               exmem_*, memwb_* - forwarding buses
//               out_*  - execute-side valid/ready and ALU operands
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_rs_val,
    input  logic [W-1:0]  in_rt_val,
    input  logic [W-1:0]  in_imm,
    input  logic [RW-1:0] in_rs_idx,
    input  logic [RW-1:0] in_rt_idx,
    input  logic [RW-1:0] in_rd_idx,
    input  logic [3:0]    in_sel,
    input  logic          in_use_imm,
    input  logic          in_reg_write,
    input  logic          exmem_wen,
    input  logic          memwb_wen,
    input  logic [RW-1:0] exmem_rd,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  exmem_res,
    input  logic [W-1:0]  memwb_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_x,
    output logic [W-1:0]  out_y,
    output logic [3:0]    out_sel,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write
);

    buf_state_t   r_state;
    id_ex_entry_t r_head;
    id_ex_entry_t r_skid;

    id_ex_entry_t w_in_raw;
    id_ex_entry_t w_in_fwd;
    id_ex_entry_t w_head_fwd;
    id_ex_entry_t w_skid_fwd;

    logic w_in_fire;
    logic w_out_fire;

    // Forwarding sources: 0/1 incoming rs/rt, 2/3 head rs/rt, 4/5 skid rs/rt.
    logic [RW-1:0] w_src_idx [6];
    logic [W-1:0]  w_src_val [6];
    logic [W-1:0]  w_fwd_val [6];

    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_in_raw           = '0;
        w_in_raw.rs_val    = in_rs_val;
        w_in_raw.rt_val    = in_rt_val;
        w_in_raw.imm       = in_imm;
        w_in_raw.rs_idx    = in_rs_idx;
        w_in_raw.rt_idx    = in_rt_idx;
        w_in_raw.rd        = in_rd_idx;
        w_in_raw.sel       = in_sel;
        w_in_raw.use_imm   = in_use_imm;
        w_in_raw.reg_write = in_reg_write;
    end

    always_comb begin
        w_src_idx[0] = w_in_raw.rs_idx;  w_src_val[0] = w_in_raw.rs_val;
        w_src_idx[1] = w_in_raw.rt_idx;  w_src_val[1] = w_in_raw.rt_val;
        w_src_idx[2] = r_head.rs_idx;    w_src_val[2] = r_head.rs_val;
        w_src_idx[3] = r_head.rt_idx;    w_src_val[3] = r_head.rt_val;
        w_src_idx[4] = r_skid.rs_idx;    w_src_val[4] = r_skid.rs_val;
        w_src_idx[5] = r_skid.rt_idx;    w_src_val[5] = r_skid.rt_val;
    end

    for (genvar g = 0; g < 6; g++) begin : g_fwd
        fwd_mux #(
            .W  (W),
            .RW (RW)
        ) u_fwd_mux (
            .idx       (w_src_idx[g]),
            .rf_val    (w_src_val[g]),
            .exmem_wen (exmem_wen),
            .exmem_rd  (exmem_rd),
            .exmem_res (exmem_res),
            .memwb_wen (memwb_wen),
            .memwb_rd  (memwb_rd),
            .memwb_res (memwb_res),
            .fwd_val   (w_fwd_val[g])
        );
    end

    always_comb begin
        w_in_fwd          = w_in_raw;
        w_in_fwd.rs_val   = w_fwd_val[0];
        w_in_fwd.rt_val   = w_fwd_val[1];
        w_head_fwd        = r_head;
        w_head_fwd.rs_val = w_fwd_val[2];
        w_head_fwd.rt_val = w_fwd_val[3];
        w_skid_fwd        = r_skid;
        w_skid_fwd.rs_val = w_fwd_val[4];
        w_skid_fwd.rt_val = w_fwd_val[5];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // Redirect: everything held or arriving this cycle is dead.
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            // Held entries keep absorbing writebacks while they wait.
            r_head <= w_head_fwd;
            r_skid <= w_skid_fwd;
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_head  <= w_in_fwd;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_head <= w_in_fwd;
                    end else if (w_in_fire) begin
                        r_skid  <= w_in_fwd;
                        r_state <= ST_TWO;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_head  <= w_skid_fwd;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_x         = r_head.rs_val;
    assign out_y         = r_head.use_imm ? r_head.imm : r_head.rt_val;
    assign out_sel       = r_head.sel;
    assign out_rd        = r_head.rd;
    assign out_reg_write = r_head.reg_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A queue-based model of
//               the stage is compared against the DUT on every falling edge;
//               directed scenarios additionally pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_rs_val, in_rt_val, in_imm;
    logic [RW-1:0] in_rs_idx, in_rt_idx, in_rd_idx;
    logic [3:0]    in_sel;
    logic          in_use_imm, in_reg_write;
    logic          exmem_wen, memwb_wen;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [W-1:0]  exmem_res, memwb_res;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_x, out_y;
    logic [3:0]    out_sel;
    logic [RW-1:0] out_rd;
    logic          out_reg_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
        .in_sel(in_sel), .in_use_imm(in_use_imm), .in_reg_write(in_reg_write),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_res(exmem_res), .memwb_res(memwb_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_sel(out_sel),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    // ---------------- reference model: a FIFO of at most two instructions
    typedef struct {
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  rs_idx, rt_idx, rd;
        logic [3:0]  sel;
        logic        use_imm, rw;
    } mentry_t;

    mentry_t q[$];

    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] v);
        if (idx == 5'd0)                      return v;
        if (exmem_wen && exmem_rd == idx)     return exmem_res;
        if (memwb_wen && memwb_rd == idx)     return memwb_res;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit      acc, dep;
            mentry_t e;
            acc = in_valid && (q.size() < 2);
            dep = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                foreach (q[i]) begin
                    q[i].rs_val = resolve(q[i].rs_idx, q[i].rs_val);
                    q[i].rt_val = resolve(q[i].rt_idx, q[i].rt_val);
                end
                if (dep) void'(q.pop_front());
                if (acc) begin
                    e.rs_val  = resolve(in_rs_idx, in_rs_val);
                    e.rt_val  = resolve(in_rt_idx, in_rt_val);
                    e.imm     = in_imm;
                    e.rs_idx  = in_rs_idx;
                    e.rt_idx  = in_rt_idx;
                    e.rd      = in_rd_idx;
                    e.sel     = in_sel;
                    e.use_imm = in_use_imm;
                    e.rw      = in_reg_write;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- continuous compare against the model
    always @(negedge clk) begin
        chk("model in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("model out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("model out_x", out_x, q[0].rs_val);
            chk("model out_y", out_y, q[0].use_imm ? q[0].imm : q[0].rt_val);
            chk("model out_sel", {28'd0, out_sel}, {28'd0, q[0].sel});
            chk("model out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            chk("model out_reg_write", {31'd0, out_reg_write}, {31'd0, q[0].rw});
        end
    end

    // ---------------- directed stimulus helpers
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [4:0] rsi, input logic [31:0] rsv,
                         input logic [4:0] rti, input logic [31:0] rtv,
                         input logic [31:0] imm, input logic [3:0] sel,
                         input logic ui, input logic [4:0] rd, input logic rw);
        in_valid = 1'b1;
        in_rs_idx = rsi; in_rs_val = rsv;
        in_rt_idx = rti; in_rt_val = rtv;
        in_imm = imm; in_sel = sel; in_use_imm = ui;
        in_rd_idx = rd; in_reg_write = rw;
    endtask

    task automatic clear_buses();
        exmem_wen = 1'b0; exmem_rd = '0; exmem_res = '0;
        memwb_wen = 1'b0; memwb_rd = '0; memwb_res = '0;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_rs_val = '0; in_rt_val = '0; in_imm = '0;
        in_rs_idx = '0; in_rt_idx = '0; in_rd_idx = '0; in_sel = '0;
        in_use_imm = 1'b0; in_reg_write = 1'b0;
        clear_buses();
        #1 rst_n = 1'b0;

        // Reset values
        cyc(2);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_x", out_x, 32'd0);
        chk("reset out_y", out_y, 32'd0);
        chk("reset out_sel", {28'd0, out_sel}, 32'd0);
        chk("reset out_rd", {27'd0, out_rd}, 32'd0);
        chk("reset out_reg_write", {31'd0, out_reg_write}, 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Single ADD, one-cycle latency
        out_ready = 1'b1;
        offer(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, c_ALU_ADD, 1'b0, 5'd4, 1'b1);
        cyc(1);
        in_valid = 1'b0;
        chk("add out_valid", {31'd0, out_valid}, 32'd1);
        chk("add out_x", out_x, 32'd5);
        chk("add out_y", out_y, 32'd7);
        chk("add out_sel", {28'd0, out_sel}, 32'd0);
        chk("add in_ready", {31'd0, in_ready}, 32'd1);
        cyc(1);

        // Forwarding priority, then index 0 never forwarded
        offer(5'd3, 32'h1111, 5'd0, 32'd0, 32'd0, c_ALU_OR, 1'b1, 5'd8, 1'b1);
        exmem_wen = 1'b1; exmem_rd = 5'd3; exmem_res = 32'hAAAA;
        memwb_wen = 1'b1; memwb_rd = 5'd3; memwb_res = 32'h5555;
        cyc(1);
        chk("fwd exmem priority", out_x, 32'hAAAA);
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        offer(5'd0, 32'h77, 5'd0, 32'd0, 32'd0, c_ALU_OR, 1'b1, 5'd8, 1'b1);
        cyc(1);
        chk("fwd idx0 passthrough", out_x, 32'h77);
        in_valid = 1'b0;
        clear_buses();
        cyc(1);

        // Back-pressure: two accepted, third held off
        out_ready = 1'b0;
        offer(5'd10, 32'h10, 5'd0, 32'd0, 32'd0, c_ALU_AND, 1'b0, 5'd1, 1'b1);
        cyc(1);
        chk("bp in_ready c1", {31'd0, in_ready}, 32'd1);
        offer(5'd11, 32'h20, 5'd0, 32'd0, 32'd0, c_ALU_AND, 1'b0, 5'd2, 1'b1);
        cyc(1);
        chk("bp in_ready c2", {31'd0, in_ready}, 32'd0);
        offer(5'd12, 32'h30, 5'd0, 32'd0, 32'd0, c_ALU_AND, 1'b0, 5'd3, 1'b1);
        cyc(1);
        chk("bp in_ready c3", {31'd0, in_ready}, 32'd0);
        chk("bp head held", out_x, 32'h10);
        out_ready = 1'b1;
        cyc(1);
        chk("bp second out_x", out_x, 32'h20);
        chk("bp in_ready back", {31'd0, in_ready}, 32'd1);
        cyc(1);
        chk("bp third out_x", out_x, 32'h30);
        in_valid = 1'b0;
        cyc(1);
        chk("bp drained", {31'd0, out_valid}, 32'd0);

        // Stalled head tracks a later writeback on rt
        out_ready = 1'b0;
        offer(5'd0, 32'd0, 5'd9, 32'h9999, 32'd0, c_ALU_SUB, 1'b0, 5'd2, 1'b1);
        cyc(1);
        in_valid = 1'b0;
        chk("stall y before", out_y, 32'h9999);
        memwb_wen = 1'b1; memwb_rd = 5'd9; memwb_res = 32'h1234;
        cyc(1);
        clear_buses();
        chk("stall y forwarded", out_y, 32'h1234);
        cyc(1);
        chk("stall y kept", out_y, 32'h1234);
        out_ready = 1'b1;
        cyc(1);
        chk("stall drained", {31'd0, out_valid}, 32'd0);

        // Flush in TWO with a concurrent input
        out_ready = 1'b0;
        offer(5'd1, 32'h100, 5'd0, 32'd0, 32'd0, c_ALU_XOR, 1'b0, 5'd5, 1'b1);
        cyc(1);
        offer(5'd1, 32'h200, 5'd0, 32'd0, 32'd0, c_ALU_XOR, 1'b0, 5'd6, 1'b1);
        cyc(1);
        chk("flush pre in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        offer(5'd1, 32'h300, 5'd0, 32'd0, 32'd0, c_ALU_XOR, 1'b0, 5'd7, 1'b1);
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush two out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush two in_ready", {31'd0, in_ready}, 32'd1);
        cyc(1);
        chk("flush two no ghost", {31'd0, out_valid}, 32'd0);

        // Flush in ONE: the input that could have been accepted is dropped
        offer(5'd1, 32'h400, 5'd0, 32'd0, 32'd0, c_ALU_NOR, 1'b0, 5'd5, 1'b1);
        cyc(1);
        flush = 1'b1;
        offer(5'd1, 32'h500, 5'd0, 32'd0, 32'd0, c_ALU_NOR, 1'b0, 5'd6, 1'b1);
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush one out_valid", {31'd0, out_valid}, 32'd0);
        cyc(1);
        chk("flush one no ghost", {31'd0, out_valid}, 32'd0);

        // Immediate operand ignores rt forwarding
        out_ready = 1'b1;
        exmem_wen = 1'b1; exmem_rd = 5'd6; exmem_res = 32'hDEAD;
        offer(5'd0, 32'd0, 5'd6, 32'h66, 32'hFFFF_FFF0, c_ALU_SLTI, 1'b1, 5'd3, 1'b1);
        cyc(1);
        in_valid = 1'b0;
        chk("imm out_y", out_y, 32'hFFFF_FFF0);
        chk("imm out_sel", {28'd0, out_sel}, 32'hB);
        clear_buses();
        cyc(1);

        // Mixed traffic, checked by the model; async reset mid-stream
        for (int n = 0; n < 400; n++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_rs_idx    = 5'($urandom_range(0, 7));
            in_rt_idx    = 5'($urandom_range(0, 7));
            in_rd_idx    = 5'($urandom_range(0, 31));
            in_rs_val    = $urandom;
            in_rt_val    = $urandom;
            in_imm       = $urandom;
            in_sel       = 4'($urandom_range(0, 15));
            in_use_imm   = 1'($urandom_range(0, 1));
            in_reg_write = 1'($urandom_range(0, 1));
            exmem_wen    = 1'($urandom_range(0, 1));
            exmem_rd     = 5'($urandom_range(0, 7));
            exmem_res    = $urandom;
            memwb_wen    = 1'($urandom_range(0, 1));
            memwb_rd     = 5'($urandom_range(0, 7));
            memwb_res    = $urandom;
            out_ready    = ($urandom_range(0, 9) < 6);
            flush        = ($urandom_range(0, 24) == 0);
            if (n == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
                chk("async reset in_ready", {31'd0, in_ready}, 32'd1);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            cyc(1);
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        clear_buses();
        cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
